// File: rtl/led_seq_pkg.sv
// led_seq_pkg: shared encodings for the LED sequencer (pattern modes, AXI
// response codes, FSM states) plus the per-mode seed helper.
// Compile-time option: LED_SEQ_VERIFY_EN adds the VERIFY readback state.
package led_seq_pkg;

    typedef enum logic [1:0] {
        MODE_COUNT  = 2'd0,
        MODE_ROTATE = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_STATIC = 2'd3
    } mode_e;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_TICK = 3'd1,
        ST_ISSUE     = 3'd2,
        ST_WAIT_B    = 3'd3
`ifdef LED_SEQ_VERIFY_EN
        ,
        ST_VERIFY    = 3'd4
`endif
    } state_e;

    // First value of a sequence for a given mode.
    function automatic logic [15:0] seed_value(input mode_e m, input logic [15:0] stat);
        logic [15:0] v;
        case (m)
            MODE_COUNT:  v = 16'h0000;
            MODE_STATIC: v = stat;
            default:     v = 16'h0001;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/led_sequencer_pattern_gen.sv
// led_pattern_gen: holds the LED value to be written next and steps or
// reseeds it on request. Latency: value_o updates the cycle after seed_i/step_i.
// No backpressure; seed_i has priority over step_i.
// Ports: clk, rst (async active-high), seed_i, step_i, mode_i,
//        static_pattern_i, value_o (current value, direction flag is internal).
module led_pattern_gen
    import led_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        seed_i,
    input  logic        step_i,
    input  mode_e       mode_i,
    input  logic [15:0] static_pattern_i,
    output logic [15:0] value_o
);

    logic [15:0] value_q, value_d;
    logic        dir_left_q, dir_left_d;

    always_comb begin
        value_d    = value_q;
        dir_left_d = dir_left_q;
        if (seed_i) begin
            value_d    = seed_value(mode_i, static_pattern_i);
            dir_left_d = 1'b1;
        end else if (step_i) begin
            case (mode_i)
                MODE_COUNT:  value_d = value_q + 16'd1;
                MODE_ROTATE: value_d = {value_q[14:0], value_q[15]};
                MODE_BOUNCE: begin
                    // Direction flips on the step that lands on an end, so the
                    // end value is written exactly once.
                    if (dir_left_q) begin
                        if (value_q[15]) begin
                            value_d    = value_q >> 1;
                            dir_left_d = 1'b0;
                        end else begin
                            value_d    = value_q << 1;
                            dir_left_d = ~value_q[14];
                        end
                    end else begin
                        if (value_q[0]) begin
                            value_d    = value_q << 1;
                            dir_left_d = 1'b1;
                        end else begin
                            value_d    = value_q >> 1;
                            dir_left_d = value_q[1];
                        end
                    end
                end
                MODE_STATIC: value_d = static_pattern_i;
                default:     value_d = value_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_q    <= 16'h0000;
            dir_left_q <= 1'b1;
        end else begin
            value_q    <= value_d;
            dir_left_q <= dir_left_d;
        end
    end

    assign value_o = value_q;

endmodule

// File: rtl/led_sequencer.sv
// led_sequencer: AXI4-Lite write master that pushes a new 16-bit LED pattern
// every max(period,1) clocks. Latency: VALIDs rise the cycle after a tick;
// VALIDs hold until their READY; one tick during a transaction is remembered.
// Ports: clk/reset (async active-high), enable, mode, period, static_pattern,
//        busy, pattern (last OKAY value), err_count, verify_err, M_AXI_* master.
// Option: define LED_SEQ_VERIFY_EN to read the register back after each write.
module led_sequencer
    import led_seq_pkg::*;
#(
    parameter int AW       = 7,
    parameter int LED_ADDR = 0,
    parameter int PW       = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    input  logic [1:0]    mode,
    input  logic [PW-1:0] period,
    input  logic [15:0]   static_pattern,
    output logic          busy,
    output logic [15:0]   pattern,
    output logic [7:0]    err_count,
    output logic          verify_err,
    output logic [AW-1:0] M_AXI_AWADDR,
    output logic          M_AXI_AWVALID,
    output logic [2:0]    M_AXI_AWPROT,
    input  logic          M_AXI_AWREADY,
    output logic [31:0]   M_AXI_WDATA,
    output logic [3:0]    M_AXI_WSTRB,
    output logic          M_AXI_WVALID,
    input  logic          M_AXI_WREADY,
    input  logic [1:0]    M_AXI_BRESP,
    input  logic          M_AXI_BVALID,
    output logic          M_AXI_BREADY,
    output logic [AW-1:0] M_AXI_ARADDR,
    output logic          M_AXI_ARVALID,
    output logic [2:0]    M_AXI_ARPROT,
    input  logic          M_AXI_ARREADY,
    input  logic [31:0]   M_AXI_RDATA,
    input  logic [1:0]    M_AXI_RRESP,
    input  logic          M_AXI_RVALID,
    output logic          M_AXI_RREADY
);

    state_e        state_q, state_d;
    mode_e         mode_q, mode_d;
    logic [PW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] cnt_last;
    logic          tick;
    logic          pend_q, pend_d;
    logic          aw_vld_q, aw_vld_d;
    logic          w_vld_q, w_vld_d;
    logic [15:0]   pattern_q, pattern_d;
    logic [7:0]    err_q, err_d;
    logic          gen_seed, gen_step;
    logic [15:0]   next_val;

    led_pattern_gen u_gen (
        .clk              (clk),
        .rst              (reset),
        .seed_i           (gen_seed),
        .step_i           (gen_step),
        .mode_i           (mode_e'(mode)),
        .static_pattern_i (static_pattern),
        .value_o          (next_val)
    );

    // period of 0 behaves like 1: a tick every enabled cycle.
    assign cnt_last = (period == '0) ? '0 : period - PW'(1);
    assign tick     = enable && (cnt_q == cnt_last);

`ifdef LED_SEQ_VERIFY_EN
    logic ar_vld_q, ar_vld_d;
    logic verr_q, verr_d;
    logic unused_rdata_hi;
    assign unused_rdata_hi = ^M_AXI_RDATA[31:16];
    assign busy = (state_q == ST_ISSUE) || (state_q == ST_WAIT_B) || (state_q == ST_VERIFY);
`else
    logic unused_rd;
    assign unused_rd = ^{M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID};
    assign busy = (state_q == ST_ISSUE) || (state_q == ST_WAIT_B);
`endif

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        pend_d    = pend_q;
        aw_vld_d  = aw_vld_q;
        w_vld_d   = w_vld_q;
        pattern_d = pattern_q;
        err_d     = err_q;
        gen_seed  = 1'b0;
        gen_step  = 1'b0;
`ifdef LED_SEQ_VERIFY_EN
        ar_vld_d  = ar_vld_q;
        verr_d    = verr_q;
`endif

        if (state_q == ST_IDLE) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = tick ? '0 : cnt_q + PW'(1);
        end else begin
            cnt_d = cnt_q;
        end

        // One-deep memory of a tick that lands mid-transaction; extra ticks merge.
        if (busy && tick) begin
            pend_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                pend_d = 1'b0;
                if (enable) begin
                    gen_seed = 1'b1;
                    mode_d   = mode_e'(mode);
                    aw_vld_d = 1'b1;
                    w_vld_d  = 1'b1;
                    state_d  = ST_ISSUE;
                end
            end
            ST_WAIT_TICK: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (tick || pend_q) begin
                    pend_d = 1'b0;
                    // A mode change restarts from that mode's seed.
                    if (mode_e'(mode) != mode_q) begin
                        gen_seed = 1'b1;
                        mode_d   = mode_e'(mode);
                    end else begin
                        gen_step = 1'b1;
                    end
                    aw_vld_d = 1'b1;
                    w_vld_d  = 1'b1;
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                aw_vld_d = aw_vld_q && !M_AXI_AWREADY;
                w_vld_d  = w_vld_q && !M_AXI_WREADY;
                if (!aw_vld_d && !w_vld_d) begin
                    state_d = ST_WAIT_B;
                end
            end
            ST_WAIT_B: begin
                if (M_AXI_BVALID) begin
                    if (M_AXI_BRESP == OKAY) begin
                        pattern_d = next_val;
                    end else if (err_q != 8'hFF) begin
                        err_d = err_q + 8'd1;
                    end
`ifdef LED_SEQ_VERIFY_EN
                    ar_vld_d = 1'b1;
                    state_d  = ST_VERIFY;
`else
                    state_d  = enable ? ST_WAIT_TICK : ST_IDLE;
`endif
                end
            end
`ifdef LED_SEQ_VERIFY_EN
            ST_VERIFY: begin
                ar_vld_d = ar_vld_q && !M_AXI_ARREADY;
                if (M_AXI_RVALID) begin
                    if ((M_AXI_RRESP != OKAY) || (M_AXI_RDATA[15:0] != next_val)) begin
                        verr_d = 1'b1;
                    end
                    state_d = enable ? ST_WAIT_TICK : ST_IDLE;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            mode_q    <= MODE_COUNT;
            cnt_q     <= '0;
            pend_q    <= 1'b0;
            aw_vld_q  <= 1'b0;
            w_vld_q   <= 1'b0;
            pattern_q <= 16'h0000;
            err_q     <= 8'h00;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
            aw_vld_q  <= aw_vld_d;
            w_vld_q   <= w_vld_d;
            pattern_q <= pattern_d;
            err_q     <= err_d;
        end
    end

`ifdef LED_SEQ_VERIFY_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ar_vld_q <= 1'b0;
            verr_q   <= 1'b0;
        end else begin
            ar_vld_q <= ar_vld_d;
            verr_q   <= verr_d;
        end
    end
    assign M_AXI_ARVALID = ar_vld_q;
    assign M_AXI_RREADY  = (state_q == ST_VERIFY);
    assign verify_err    = verr_q;
`else
    assign M_AXI_ARVALID = 1'b0;
    assign M_AXI_RREADY  = 1'b1;
    assign verify_err    = 1'b0;
`endif

    assign M_AXI_AWADDR  = AW'(LED_ADDR);
    assign M_AXI_ARADDR  = AW'(LED_ADDR);
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_WSTRB   = 4'hF;
    assign M_AXI_WDATA   = {16'h0000, next_val};
    assign M_AXI_AWVALID = aw_vld_q;
    assign M_AXI_WVALID  = w_vld_q;
    assign M_AXI_BREADY  = (state_q == ST_WAIT_B);
    assign pattern       = pattern_q;
    assign err_count     = err_q;

endmodule

// File: tb/tb_led_sequencer.sv
module tb_led_sequencer;
    import led_seq_pkg::*;

    localparam int AW = 7;
    localparam int PW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic [PW-1:0] period = 4;
    logic [15:0]   static_pattern = 16'h0000;
    logic          busy;
    logic [15:0]   pattern;
    logic [7:0]    err_count;
    logic          verify_err;
    logic [AW-1:0] awaddr, araddr;
    logic          awvalid, wvalid, arvalid, bready, rready;
    logic [2:0]    awprot, arprot;
    logic [31:0]   wdata;
    logic [3:0]    wstrb;
    logic          awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
    logic [1:0]    bresp = 2'b00, rresp = 2'b00;
    logic [31:0]   rdata = 32'h0;

    led_sequencer #(.AW(AW), .LED_ADDR(0), .PW(PW)) dut (
        .clk(clk), .reset(reset), .enable(enable), .mode(mode), .period(period),
        .static_pattern(static_pattern), .busy(busy), .pattern(pattern),
        .err_count(err_count), .verify_err(verify_err),
        .M_AXI_AWADDR(awaddr), .M_AXI_AWVALID(awvalid), .M_AXI_AWPROT(awprot),
        .M_AXI_AWREADY(awready), .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb),
        .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready), .M_AXI_BRESP(bresp),
        .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready), .M_AXI_ARADDR(araddr),
        .M_AXI_ARVALID(arvalid), .M_AXI_ARPROT(arprot), .M_AXI_ARREADY(arready),
        .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid),
        .M_AXI_RREADY(rready)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Slave model configuration (set by the test sequence).
    int         aw_delay = 0, w_delay = 0, b_delay = 0;
    logic [1:0] bresp_cfg = 2'b00;
    bit         rforce = 1'b0;

    // Slave model state and records.
    int          cyc = 0;
    int          aw_wait, w_wait, b_wait;
    int          aw_n, w_n, b_iss, b_done, ar_n, r_iss;
    int          aw_hi, w_hi, ar_hi;
    bit          b_hs, r_hs;
    logic [15:0] last_w;
    logic [15:0] wq[$];
    int          aw_cyc[$];
    int          b_cyc[$];

    // All slave decisions are made at the falling edge; a VALID/READY pair
    // seen high here completes on the following rising edge.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                aw_wait = 0; w_wait = 0; b_wait = 0;
                aw_n = 0; w_n = 0; b_iss = 0; b_done = 0; ar_n = 0; r_iss = 0;
                aw_hi = 0; w_hi = 0; ar_hi = 0; b_hs = 0; r_hs = 0; last_w = 16'h0;
                wq.delete(); aw_cyc.delete(); b_cyc.delete();
                awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
            end else begin
                if (b_hs) begin bvalid = 0; b_hs = 0; b_done++; end
                if (!bvalid && aw_n > b_iss && w_n > b_iss) begin
                    if (b_wait >= b_delay) begin
                        bvalid = 1; bresp = bresp_cfg; b_iss++; b_wait = 0;
                    end else b_wait++;
                end
                if (bvalid && bready) begin b_hs = 1; b_cyc.push_back(cyc); end

                if (r_hs) begin rvalid = 0; r_hs = 0; end
                if (!rvalid && ar_n > r_iss) begin
                    rvalid = 1; rresp = 2'b00; r_iss++;
                    rdata = rforce ? 32'h0000_1234 : {16'h0, last_w};
                end
                if (rvalid && rready) r_hs = 1;

                if (awvalid) begin
                    aw_hi++;
                    if (aw_wait >= aw_delay) begin
                        awready = 1; aw_n++; aw_cyc.push_back(cyc); aw_wait = 0;
                    end else begin awready = 0; aw_wait++; end
                end else awready = 0;

                if (wvalid) begin
                    w_hi++;
                    if (w_wait >= w_delay) begin
                        wready = 1; w_n++; wq.push_back(wdata[15:0]); last_w = wdata[15:0]; w_wait = 0;
                    end else begin wready = 0; w_wait++; end
                end else wready = 0;

                if (arvalid) begin ar_hi++; arready = 1; ar_n++; end
                else arready = 0;
            end
        end
    end

    function automatic logic [31:0] wv(input int i);
        return (wq.size() > i) ? {16'h0, wq[i]} : 32'hxxxx_xxxx;
    endfunction

    function automatic int gap_after_b(input int k);
        return (aw_cyc.size() > k + 1 && b_cyc.size() > k) ? aw_cyc[k+1] - b_cyc[k] : -1;
    endfunction

    task automatic step(input int n);
        repeat (n) begin @(negedge clk); #1; end
    endtask

    task automatic wait_w(input int n, input int budget, input string tag);
        int k = 0;
        while (w_n < n && k < budget) begin @(negedge clk); #1; k++; end
        if (w_n < n) chk({tag, "_timeout"}, w_n, n);
    endtask

    task automatic wait_b(input int n, input int budget, input string tag);
        int k = 0;
        while (b_done < n && k < budget) begin @(negedge clk); #1; k++; end
        if (b_done < n) chk({tag, "_timeout"}, b_done, n);
    endtask

    task automatic do_reset();
        enable = 0;
        reset = 1;
        repeat (3) @(negedge clk);
        #2 reset = 0;
        step(1);
    endtask

`ifdef LED_SEQ_VERIFY_EN
    localparam int B_TO_AW = 4;
`else
    localparam int B_TO_AW = 2;
`endif

    initial begin
        int base;
        logic [15:0] exp_pat;

        // Reset state and constant outputs.
        step(3);
        chk("rst_awvalid", awvalid, 0);
        chk("rst_wvalid", wvalid, 0);
        chk("rst_arvalid", arvalid, 0);
        chk("rst_bready", bready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pattern", pattern, 0);
        chk("rst_err", err_count, 0);
        chk("rst_verr", verify_err, 0);
        chk("const_wstrb", wstrb, 4'hF);
        chk("const_prot", {awprot, arprot}, 0);
        chk("const_addr", {awaddr, araddr}, 0);
        do_reset();
        chk("idle_busy", busy, 0);

        // Count mode, period 4.
        period = 4; mode = 2'd0; enable = 1;
        wait_w(3, 100, "cnt");
        chk("cnt_w0", wv(0), 16'h0000);
        chk("cnt_w1", wv(1), 16'h0001);
        chk("cnt_w2", wv(2), 16'h0002);
`ifndef LED_SEQ_VERIFY_EN
        chk("cnt_space01", aw_cyc[1] - aw_cyc[0], 4);
        chk("cnt_space12", aw_cyc[2] - aw_cyc[1], 4);
        chk("cnt_no_ar", ar_hi, 0);
`endif
        wait_b(2, 100, "cnt_b2");
        chk("cnt_pat_b2", pattern, 16'h0001);
        wait_b(3, 100, "cnt_b3");
        chk("cnt_pat_b3", pattern, 16'h0002);
        chk("cnt_err", err_count, 0);
        chk("cnt_verr", verify_err, 0);

        // Bounce mode: 0x0001 up to 0x8000 once, then back down.
        do_reset();
        period = 2; mode = 2'd2; enable = 1;
        wait_w(18, 600, "bnc");
        for (int i = 0; i < 18; i++) begin
            logic [15:0] e;
            e = (i <= 15) ? (16'h0001 << i) : (i == 16 ? 16'h4000 : 16'h2000);
            chk($sformatf("bnc_w%0d", i), wv(i), {16'h0, e});
        end

        // AWREADY late, WREADY immediate.
        do_reset();
        period = 100; mode = 2'd0; aw_delay = 2; enable = 1;
        step(20);
        chk("dly_aw_hi", aw_hi, 3);
        chk("dly_w_hi", w_hi, 1);
        chk("dly_aw_n", aw_n, 1);
        chk("dly_b_done", b_done, 1);
        aw_delay = 0;

        // Error responses saturate the counter; pattern keeps last OKAY.
        do_reset();
        period = 1; mode = 2'd0; bresp_cfg = OKAY; enable = 1;
        wait_b(3, 100, "err_ok");
        enable = 0;
        step(12);
        chk("err_idle", busy, 0);
        exp_pat = 16'(w_n - 1);
        chk("err_pat_ok", pattern, exp_pat);
        base = b_done;
        bresp_cfg = DECERR; enable = 1;
        wait_b(base + 100, 1000, "err100");
        chk("err_cnt100", err_count, 100);
        wait_b(base + 300, 3000, "err300");
        chk("err_sat", err_count, 255);
        chk("err_pat_kept", pattern, exp_pat);
        enable = 0; bresp_cfg = OKAY;

        // Period 1 with slow B: merged pending tick, back-to-back values.
        do_reset();
        period = 1; mode = 2'd0; b_delay = 5; enable = 1;
        wait_w(6, 200, "pend");
        wait_b(5, 200, "pend_b");
        for (int i = 0; i < 6; i++) chk($sformatf("pend_w%0d", i), wv(i), i);
        for (int k = 0; k < 3; k++) chk($sformatf("pend_gap%0d", k), gap_after_b(k), B_TO_AW);

        // Period 3 with long B: a tick caught mid-transaction is not lost.
        do_reset();
        period = 3; mode = 2'd0; b_delay = 8; enable = 1;
        wait_w(5, 300, "pend3");
        wait_b(4, 300, "pend3_b");
        for (int k = 0; k < 3; k++) chk($sformatf("pend3_gap%0d", k), gap_after_b(k), B_TO_AW);
        b_delay = 0;

        // Static mode resampling, then mode change reseeds.
        do_reset();
        period = 8; mode = 2'd3; static_pattern = 16'hBEEF; enable = 1;
        wait_w(1, 50, "st1");
        static_pattern = 16'h1234;
        wait_w(2, 50, "st2");
        mode = 2'd1;
        wait_w(4, 100, "st4");
        chk("st_w0", wv(0), 16'hBEEF);
        chk("st_w1", wv(1), 16'h1234);
        chk("st_w2_reseed", wv(2), 16'h0001);
        chk("st_w3_rot", wv(3), 16'h0002);

        // Reset asserted while the write is held in ISSUE.
        do_reset();
        period = 4; mode = 2'd1; enable = 1;
        wait_w(3, 100, "rsi");
        aw_delay = 20; w_delay = 20;
        begin
            int k = 0;
            while (!(awvalid && wvalid) && k < 50) begin @(negedge clk); #1; k++; end
        end
        chk("rsi_pre_vld", {awvalid, wvalid}, 2'b11);
        #1 reset = 1;
        #1;
        chk("rsi_awvalid", awvalid, 0);
        chk("rsi_wvalid", wvalid, 0);
        chk("rsi_busy", busy, 0);
        repeat (2) @(negedge clk);
        aw_delay = 0; w_delay = 0; rforce = 1;
        #2 reset = 0;
        wait_w(1, 50, "rsi_w");
        chk("rsi_seed", wv(0), 16'h0001);
        wait_b(1, 50, "rsi_b");
        chk("rsi_pat", pattern, 16'h0001);
        step(8);
`ifdef LED_SEQ_VERIFY_EN
        chk("rsi_verr", verify_err, 1);
`else
        chk("rsi_verr", verify_err, 0);
        chk("rsi_no_ar", ar_hi, 0);
`endif
        enable = 0;
        step(10);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not complete (%0d/%0d so far)", n_pass, n_chk);
        $fatal(1);
    end

endmodule

// File: doc/led_sequencer.md
Name: led_sequencer

Overview:
- AXI4-Lite write master that sequences the 16-bit LED output register of the AXI LED slave.
- Generates a new LED pattern every programmable number of clocks and writes it as a single 32-bit AXI4-Lite write.
- Sits between board-level control inputs and the LED slave; the sequencer and the slave share the same clock.

Parameters:
- AW, 7: AXI address width; matches the LED slave.
- LED_ADDR, 0: byte address of the LED register at the slave.
- PW, 32: width of the period input.

Ports:
- clk  in  1  sole clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  1 = run the sequence.
- mode  in  2  0 = binary count, 1 = rotate-left, 2 = bounce, 3 = static.
- period  in  PW  clocks between pattern updates; 0 is treated as 1.
- static_pattern  in  16  value written in mode 3.
- busy  out  1  AXI transaction in flight.
- pattern  out  16  last value whose write got an OKAY response.
- err_count  out  8  saturating count of non-OKAY BRESP.
- verify_err  out  1  sticky readback mismatch flag (optional feature).
- M_AXI_AWADDR/AWVALID/AWPROT(3)/AWREADY  out/out/out/in  AW channel.
- M_AXI_WDATA(32)/WSTRB(4)/WVALID/WREADY  out/out/out/in  W channel.
- M_AXI_BRESP(2)/BVALID/BREADY  in/in/out  B channel.
- M_AXI_ARADDR/ARVALID/ARPROT(3)/ARREADY  out/out/out/in  AR channel.
- M_AXI_RDATA(32)/RRESP(2)/RVALID/RREADY  in/in/in/out  R channel.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-high.
- Reset values: all VALIDs 0, BREADY 0, busy 0, pattern 0, err_count 0, verify_err 0, state IDLE, tick counter 0.
- Reset mid-transaction: VALIDs drop immediately. The slave must be held in reset at the same time.
- Constant outputs: AWPROT = ARPROT = 0, WSTRB = 4'hF, AWADDR = ARADDR = LED_ADDR. WDATA = {16'h0, next}.
- Tick counter: runs only while enabled and counts 0 .. max(period,1)-1. The terminal count produces a one-cycle tick.
- Pending ticks: a tick arriving while busy sets a one-deep pending flag. Further ticks while the flag is set are discarded.
- State IDLE: on enable = 1, load the seed (count 0x0000, rotate/bounce 0x0001, static = static_pattern), clear the tick counter, go to ISSUE.
- State WAIT_TICK: on tick or pending, compute next from the current value, clear pending, go to ISSUE. On enable = 0, go to IDLE.
- State ISSUE: assert AWVALID and WVALID together on the cycle after entry.
  - Each VALID drops independently after its own READY handshake.
  - When both handshakes are done, go to WAIT_B.
- State WAIT_B: BREADY = 1. On BVALID:
  - OKAY: update pattern.
  - Otherwise: err_count += 1, saturating at 255.
  - Then go to VERIFY if the optional feature is compiled in, else WAIT_TICK (IDLE if enable = 0).
- enable dropping mid-transaction: the current transaction completes, then the block returns to IDLE.
- busy = state in {ISSUE, WAIT_B, VERIFY}.
- Pattern arithmetic, all 16-bit:
  - Count: +1, wrapping 0xFFFF → 0x0000.
  - Rotate: bit15 → bit0.
  - Bounce: a direction flag reverses on reaching 0x8000 or 0x0001 (0x4000 → 0x8000 → 0x4000). Direction resets to left on seed.
  - Static: resamples static_pattern at each tick.
- Mode changes: sampled at tick. A change of mode reseeds the pattern instead of stepping it.

Optional Feature:
- Macro LED_SEQ_VERIFY_EN.
- With the macro: after BRESP, state VERIFY issues an AR to LED_ADDR with RREADY = 1. On R, verify_err is set if RRESP ≠ OKAY or RDATA[15:0] ≠ the written value. verify_err clears only on reset.
- Without the macro: ARVALID = 0, RREADY = 1, verify_err = 0, and the VERIFY state is absent.

Decomposition:
- Package led_seq_pkg: mode encodings (MODE_COUNT, MODE_ROTATE, MODE_BOUNCE, MODE_STATIC), AXI response constants (OKAY = 0, SLVERR = 2, DECERR = 3), state encoding.
- Sub-module led_pattern_gen: registered next-pattern logic with seed/step inputs and the direction flag.
- The AXI FSM and tick counter stay in the top module.

Test Plan:
- period = 4, mode 0, slave with AWREADY/WREADY = 1: writes 0x0000, 0x0001, 0x0002 spaced 4 clocks apart; pattern tracks them; err_count = 0.
- Mode 2, seed 0x0001, 17 ticks: WDATA steps 0x0001 … 0x8000, then 0x4000; no repeated 0x8000.
- AWREADY delayed 3 cycles, WREADY immediate: WVALID drops after 1 cycle, AWVALID held 3 cycles; a single B is consumed.
- BRESP = DECERR for 300 writes: err_count saturates at 255; pattern is unchanged from the last OKAY.
- period = 1 with BVALID delayed 5 cycles: one merged pending tick, so the next write follows immediately and the sequence has no gaps in values.
- Reset asserted during ISSUE: AWVALID = WVALID = 0 asynchronously. After release with enable = 1, the first write is the seed. With LED_SEQ_VERIFY_EN and RDATA forced to 0x1234, verify_err = 1.
